// File: rtl/t8086_pkg.sv
// rtl/t8086_pkg.sv - shared 8086 core constants, types and physical address helper
//
// Purpose : common definitions for the bus interface unit and the EU data path.
// Contents: PFQ_DEPTH     - default prefetch queue capacity in bytes
//           RESET_CS/IP   - code segment / instruction pointer loaded on reset
//           paddr_t       - 20-bit physical address
//           far_ptr_t     - segment:offset pair
//           phys_addr()   - (seg*16 + off) mod 2^20
package t8086_pkg;

   localparam int          PFQ_DEPTH = 6;
   localparam logic [15:0] RESET_CS  = 16'hFFFF;
   localparam logic [15:0] RESET_IP  = 16'h0000;

   typedef logic [19:0] paddr_t;

   typedef struct packed {
      logic [15:0] cs;
      logic [15:0] ip;
   } far_ptr_t;

   // The 20-bit sum truncates naturally, giving the 8086 wrap at 1 MiB.
   function automatic paddr_t phys_addr(input logic [15:0] seg, input logic [15:0] off);
      return {seg, 4'h0} + {4'h0, off};
   endfunction

endpackage

// File: rtl/biu_prefetch_queue_if.sv
// rtl/biu_prefetch_queue_if.sv - byte-wide RAM code-fetch read port
//
// Purpose : bundles the prefetch read port between the BIU and the RAM.
// Signals : ram_rd_en   - fetch read enable (BIU -> RAM)
//           ram_rd_addr - 20-bit physical fetch address (BIU -> RAM)
//           ram_rd_data - read data, combinational in the same cycle (RAM -> BIU)
// Modports: master - the BIU side, slave - the RAM side
interface biu_prefetch_queue_if;
   import t8086_pkg::*;

   logic       ram_rd_en;
   paddr_t     ram_rd_addr;
   logic [7:0] ram_rd_data;

   modport master (
      output ram_rd_en,
      output ram_rd_addr,
      input  ram_rd_data
   );

   modport slave (
      input  ram_rd_en,
      input  ram_rd_addr,
      output ram_rd_data
   );

endinterface

// File: rtl/biu_prefetch_queue_fifo.sv
// rtl/biu_prefetch_queue_fifo.sv - DEPTH x 8 circular byte buffer with 0/1/2 pop and two-byte peek
//
// Purpose : storage for the instruction prefetch queue.
// Ports   : clk, rst_n   - clock, synchronous active-low reset
//           clr_i        - discard contents (flush), overrides push and pop
//           push_i       - write push_data_i at the tail this cycle
//           push_data_i  - byte to enqueue
//           pop_num_i    - bytes requested to dequeue (3 behaves as 2)
//           pop_eff_o    - bytes actually dequeued this cycle
//           count_o      - bytes held
//           byte0_o      - oldest byte, 0 when empty
//           byte1_o      - second-oldest byte, 0 when fewer than two held
module pfq_fifo
   import t8086_pkg::*;
#(
   parameter int DEPTH = PFQ_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic [1:0] pop_num_i,
   output logic [1:0] pop_eff_o,
   output logic [2:0] count_o,
   output logic [7:0] byte0_o,
   output logic [7:0] byte1_o
);

   logic [7:0] mem_q [DEPTH];
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] count_q,  count_d;
   logic [1:0] pop_clip;
   logic [1:0] pop_eff;
   logic       push_ok;
   logic [2:0] rd_ptr_nxt1;

   // Pointer advance by 0..2 modulo DEPTH; p < DEPTH <= 7 so one subtraction suffices.
   function automatic logic [2:0] ptr_add(input logic [2:0] p, input logic [1:0] n);
      logic [3:0] s;
      s = {1'b0, p} + {2'b00, n};
      if (s >= 4'(DEPTH)) begin
         s = s - 4'(DEPTH);
      end
      return s[2:0];
   endfunction

   always_comb begin
      pop_clip = (pop_num_i == 2'd3) ? 2'd2 : pop_num_i;
      pop_eff  = 2'd0;
      if (!clr_i) begin
         // Clamp to what is held so the count can never underflow.
         pop_eff = ({1'b0, pop_clip} > count_q) ? count_q[1:0] : pop_clip;
      end
      push_ok     = push_i & ~clr_i;
      rd_ptr_nxt1 = ptr_add(rd_ptr_q, 2'd1);
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         rd_ptr_d = 3'd0;
         wr_ptr_d = 3'd0;
         count_d  = 3'd0;
      end else begin
         rd_ptr_d = ptr_add(rd_ptr_q, pop_eff);
         if (push_ok) begin
            wr_ptr_d = ptr_add(wr_ptr_q, 2'd1);
         end
         count_d = count_q - {1'b0, pop_eff} + {2'b00, push_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= 3'd0;
         wr_ptr_q <= 3'd0;
         count_q  <= 3'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; the count gates what is visible.
   always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign pop_eff_o = pop_eff;
   assign count_o   = count_q;
   assign byte0_o   = (count_q >= 3'd1) ? mem_q[rd_ptr_q]    : 8'h00;
   assign byte1_o   = (count_q >= 3'd2) ? mem_q[rd_ptr_nxt1] : 8'h00;

endmodule

// File: rtl/biu_prefetch_queue.sv
// rtl/biu_prefetch_queue.sv - 8086-style BIU instruction prefetch queue
//
// Purpose : fetches sequential code bytes at CS:IP into a small queue drained by the EU.
// Ports   : clk, rst_n   - clock, synchronous active-low reset
//           flush        - discard queue, restart at flush_cs:flush_ip
//           flush_cs/ip  - new fetch address on flush
//           eu_busy      - EU owns the RAM read port; no fetch this cycle
//           pop_num      - bytes consumed this cycle (0..2, 3 behaves as 2)
//           ram          - RAM read port (master side)
//           q_byte0/1    - oldest / second-oldest queued byte
//           q_count      - bytes queued
//           q_ip         - IP of q_byte0
module biu_prefetch_queue #(
   parameter int          DEPTH    = t8086_pkg::PFQ_DEPTH,
   parameter logic [15:0] RESET_CS = t8086_pkg::RESET_CS,
   parameter logic [15:0] RESET_IP = t8086_pkg::RESET_IP
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [15:0]                 flush_cs,
   input  logic [15:0]                 flush_ip,
   input  logic                        eu_busy,
   input  logic [1:0]                  pop_num,
   biu_prefetch_queue_if.master        ram,
   output logic [7:0]                  q_byte0,
   output logic [7:0]                  q_byte1,
   output logic [2:0]                  q_count,
   output logic [15:0]                 q_ip
);
   import t8086_pkg::*;

   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   far_ptr_t    fetch_q, fetch_d;
   logic [15:0] q_ip_q,  q_ip_d;
   logic        fetch;
   logic [1:0]  pop_eff;
   logic [2:0]  count;

   // Fullness uses the pre-pop count: a pop never makes room for a same-cycle fetch.
   assign fetch = rst_n & ~flush & ~eu_busy & (count < DEPTH_C);

   always_comb begin
      fetch_d = fetch_q;
      q_ip_d  = q_ip_q;
      if (flush) begin
         fetch_d.cs = flush_cs;
         fetch_d.ip = flush_ip;
         q_ip_d     = flush_ip;
      end else begin
         // IP wraps within the segment; no carry into CS.
         if (fetch) begin
            fetch_d.ip = fetch_q.ip + 16'd1;
         end
         q_ip_d = q_ip_q + {14'd0, pop_eff};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_q.cs <= RESET_CS;
         fetch_q.ip <= RESET_IP;
         q_ip_q     <= RESET_IP;
      end else begin
         fetch_q <= fetch_d;
         q_ip_q  <= q_ip_d;
      end
   end

   assign ram.ram_rd_en   = fetch;
   assign ram.ram_rd_addr = phys_addr(fetch_q.cs, fetch_q.ip);

   pfq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (flush),
      .push_i      (fetch),
      .push_data_i (ram.ram_rd_data),
      .pop_num_i   (pop_num),
      .pop_eff_o   (pop_eff),
      .count_o     (count),
      .byte0_o     (q_byte0),
      .byte1_o     (q_byte1)
   );

   assign q_count = count;
   assign q_ip    = q_ip_q;

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// tb/tb_biu_prefetch_queue.sv - scoreboard bench for the prefetch queue against a byte-queue model
module tb_biu_prefetch_queue;

   localparam int DEPTH = 6;

   typedef struct {
      bit          full;
      logic        en;
      logic [19:0] addr;
      logic [2:0]  cnt;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] ip;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] flush_cs = 16'h0;
   logic [15:0] flush_ip = 16'h0;
   logic        eu_busy = 1'b0;
   logic [1:0]  pop_num = 2'd0;
   logic [7:0]  q_byte0, q_byte1;
   logic [2:0]  q_count;
   logic [15:0] q_ip;

   biu_prefetch_queue_if ram_if ();

   biu_prefetch_queue dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .flush_cs (flush_cs),
      .flush_ip (flush_ip),
      .eu_busy  (eu_busy),
      .pop_num  (pop_num),
      .ram      (ram_if.master),
      .q_byte0  (q_byte0),
      .q_byte1  (q_byte1),
      .q_count  (q_count),
      .q_ip     (q_ip)
   );

   always #5 clk = ~clk;

   logic [7:0]  tmem [0:1048575];
   logic [7:0]  mq [$];
   logic [15:0] m_cs, m_fip, m_hip;
   bit          m_valid = 1'b0;
   exp_t        sb [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // One clock cycle: drive inputs, record expected outputs, advance the model.
   task automatic cyc(input bit rst, input bit fl, input logic [15:0] fcs, input logic [15:0] fip,
                      input bit busy, input logic [1:0] pop);
      exp_t        e;
      int          pc, eff;
      bit          fe;
      logic [19:0] a;
      @(negedge clk);
      rst_n = rst; flush = fl; flush_cs = fcs; flush_ip = fip; eu_busy = busy; pop_num = pop;
      ram_if.ram_rd_data = tmem[ram_if.ram_rd_addr];
      a  = 20'((int'(m_cs) * 16 + int'(m_fip)) % 1048576);
      fe = rst && !fl && !busy && (mq.size() < DEPTH);
      e.full = m_valid;
      e.en   = fe;
      e.addr = a;
      e.cnt  = 3'(mq.size());
      e.b0   = (mq.size() >= 1) ? mq[0] : 8'h00;
      e.b1   = (mq.size() >= 2) ? mq[1] : 8'h00;
      e.ip   = m_hip;
      sb.push_back(e);
      if (!rst) begin
         mq.delete(); m_cs = 16'hFFFF; m_fip = 16'h0000; m_hip = 16'h0000; m_valid = 1'b1;
      end else if (fl) begin
         mq.delete(); m_cs = fcs; m_fip = fip; m_hip = fip; m_valid = 1'b1;
      end else if (m_valid) begin
         pc  = (pop == 2'd3) ? 2 : int'(pop);
         eff = (pc < mq.size()) ? pc : mq.size();
         repeat (eff) void'(mq.pop_front());
         m_hip = m_hip + 16'(eff);
         if (fe) begin
            mq.push_back(tmem[a]);
            m_fip = m_fip + 16'd1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
   endtask

   // Monitor: the status outputs are presented every cycle, checked just before the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ram_rd_en", 20'(ram_if.ram_rd_en), 20'(e.en));
            if (e.full) begin
               chk("ram_rd_addr", ram_if.ram_rd_addr, e.addr);
               chk("q_count", 20'(q_count), 20'(e.cnt));
               chk("q_byte0", 20'(q_byte0), 20'(e.b0));
               chk("q_byte1", 20'(q_byte1), 20'(e.b1));
               chk("q_ip", 20'(q_ip), 20'(e.ip));
            end
         end
      end
   end

   initial begin
      logic [7:0] boot [8];
      boot = '{8'hEA, 8'h00, 8'h7C, 8'h00, 8'h00, 8'h90, 8'h90, 8'h90};
      for (int i = 0; i < 1048576; i++) tmem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) tmem[20'hFFFF0 + i] = boot[i];
      ram_if.ram_rd_data = 8'h00;

      // Reset, then fill from FFFF0 until full.
      cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
      cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
      idle(8);
      // Pop two from a full queue, refill.
      cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd2);
      idle(4);
      // Empty queue held off by the EU.
      cyc(1'b1, 1'b1, 16'h2000, 16'h0100, 1'b0, 2'd0);
      repeat (3) cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
      idle(2);
      // IP wraps inside the segment.
      cyc(1'b1, 1'b1, 16'h1000, 16'hFFFE, 1'b0, 2'd0);
      idle(4);
      // 20-bit physical wrap.
      cyc(1'b1, 1'b1, 16'hFFFF, 16'h0010, 1'b0, 2'd0);
      idle(2);
      // Flush wins over pop and fetch at count 4.
      cyc(1'b1, 1'b1, 16'h3000, 16'h0000, 1'b0, 2'd0);
      idle(4);
      cyc(1'b1, 1'b1, 16'h4000, 16'h1234, 1'b0, 2'd2);
      // Pop 2 at count 1 with a concurrent fetch.
      idle(1);
      cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd2);
      idle(1);
      // Pop 3 behaves as 2; reset mid-operation.
      idle(3);
      cyc(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 2'd3);
      cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd1);
      idle(2);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0),
             16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom));
      end

      @(negedge clk);
      #6;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
